// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan sequencer and debouncer for a 4x4 matrix keypad. Columns are driven
// one-hot, rows are sampled at the end of each column dwell to build a 16-bit
// frame, and single-key presses are confirmed over DEBOUNCE consecutive
// identical frames. Confirmed key codes are queued in a small FIFO that the
// bus-side consumer drains with a valid/ready handshake.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   When defined, a held key is re-pushed REPEAT_DELAY frames after the
//   initial push and every REPEAT_PERIOD frames after that, as long as every
//   frame keeps showing that same single key.
//
// Parameters:
//   SCAN_DIV      cycles each column is driven (>= 2)
//   DEBOUNCE      identical frames needed to confirm press / release (1..15)
//   FIFO_DEPTH    key FIFO entries (power of two, >= 2)
//   REPEAT_DELAY  frames from initial push to first repeat (macro only)
//   REPEAT_PERIOD frames between later repeats (macro only)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_rows[3:0]    keypad rows, bit 3 = row 0, 1 = key closed in driven column
//   o_cols[3:0]    one-hot column drive, bit 3 = column 0
//   o_key_valid    FIFO non-empty
//   o_key_code[7:0] FIFO head, row*4 + col + 1, 0 when empty
//   i_key_ready    consumer accepts the head while o_key_valid = 1
//   o_overflow     sticky: a confirmed key was dropped on a full FIFO
//   i_clr_overflow clears o_overflow (a same-cycle set wins)
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_rows,
    output logic [3:0] o_cols,
    output logic       o_key_valid,
    output logic [7:0] o_key_code,
    input  logic       i_key_ready,
    output logic       o_overflow,
    input  logic       i_clr_overflow
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB      = 4'(DEBOUNCE);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);
`endif

    // -------------------------------------------------------------------------
    // Column scanner and frame capture
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [15:0]      r_frame;
    logic [15:0]      w_frame;
    logic             w_dwell_end;
    logic             w_frame_end;

    assign w_dwell_end = (r_div == DIV_LAST);
    assign w_frame_end = w_dwell_end && (r_col == 2'd3);
    assign o_cols      = 4'b1000 >> r_col;

    // The classifier looks at the frame including the row sample taken this
    // cycle, so the frame-end decision never lags one column behind.
    always_comb begin
        w_frame = r_frame;
        w_frame[{r_col, 2'b00} +: 4] = i_rows;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div   <= '0;
            r_col   <= 2'd0;
            r_frame <= 16'd0;
        end else if (w_dwell_end) begin
            r_div   <= '0;
            r_col   <= r_col + 2'd1;
            r_frame <= w_frame;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame classification: 0, 1 or "2 or more" keys, plus the bit index of
    // the key when exactly one is set.
    // -------------------------------------------------------------------------
    logic [1:0] w_nkeys;
    logic [3:0] w_idx;
    logic       w_empty;
    logic       w_single;
    logic [7:0] w_code;

    always_comb begin
        w_nkeys = 2'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame[i]) begin
                w_nkeys = (w_nkeys == 2'd0) ? 2'd1 : 2'd2;
                w_idx   = 4'(i);
            end
        end
    end

    assign w_empty  = (w_nkeys == 2'd0);
    assign w_single = (w_nkeys == 2'd1);

    // Frame bit c*4 + (3-r) holds row r / column c, so the row is the inverted
    // low pair and the column the high pair.
    assign w_code = 8'({~w_idx[1:0], w_idx[3:2]}) + 8'd1;

    // -------------------------------------------------------------------------
    // Debounce FSM (advances on frame-end only)
    // -------------------------------------------------------------------------
    logic [1:0] r_state, w_state_nxt;
    logic [3:0] r_cand,  w_cand_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic       w_push;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
    logic             r_rep_on,  w_rep_on_nxt;
    logic             r_rep_first, w_rep_first_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_on_nxt    = r_rep_on;
        w_rep_first_nxt = r_rep_first;
`endif
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_idx;
                        if (DEB == 4'd1) begin
                            w_push      = 1'b1;
                            w_state_nxt = S_HELD;
                            w_cnt_nxt   = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            w_rep_cnt_nxt   = '0;
                            w_rep_on_nxt    = 1'b1;
                            w_rep_first_nxt = 1'b1;
`endif
                        end else begin
                            w_state_nxt = S_CONFIRM;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (w_single && (w_idx == r_cand)) begin
                        if (r_cnt + 4'd1 == DEB) begin
                            w_push      = 1'b1;
                            w_state_nxt = S_HELD;
                            w_cnt_nxt   = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            w_rep_cnt_nxt   = '0;
                            w_rep_on_nxt    = 1'b1;
                            w_rep_first_nxt = 1'b1;
`endif
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end else begin
                        // A different single key does not restart the
                        // candidate directly; it must start again from IDLE.
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_HELD: begin
                    // r_cnt counts consecutive empty frames; any activity
                    // restarts the release window.
                    if (w_empty) begin
                        if (r_cnt + 4'd1 == DEB) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end else begin
                        w_cnt_nxt = 4'd0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    // Repeat only while the frame is still exactly the
                    // confirmed key; once broken it stays off until the next
                    // confirmed press.
                    if (w_single && (w_idx == r_cand) && r_rep_on) begin
                        if (r_rep_first ? (r_rep_cnt + 1'b1 == REP_DLY)
                                        : (r_rep_cnt + 1'b1 == REP_PER)) begin
                            w_push          = 1'b1;
                            w_rep_cnt_nxt   = '0;
                            w_rep_first_nxt = 1'b0;
                        end else begin
                            w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                        end
                    end else begin
                        w_rep_on_nxt = 1'b0;
                    end
`endif
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cand  <= 4'd0;
            r_cnt   <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_on    <= 1'b0;
            r_rep_first <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_on    <= w_rep_on_nxt;
            r_rep_first <= w_rep_first_nxt;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Key FIFO with registered head outputs
    // -------------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_key_valid;
    logic [7:0]       r_key_code;
    logic [7:0]       w_head_nxt;
    logic             r_ovf;
    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;
    logic             w_drop;

    assign w_pop    = r_key_valid & i_key_ready;
    assign w_full   = (r_count == FULL_CNT);
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign w_wr_en  = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;
    assign w_rd_nxt = w_pop ? r_rd + 1'b1 : r_rd;

    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = 8'd0;
        if (w_wr_en && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_wr_en && w_pop)
            w_count_nxt = r_count - 1'b1;
        // The write pointer can only meet the next read pointer with a write
        // pending when the queue would otherwise be empty, so the new code
        // becomes the head directly.
        if (w_count_nxt == '0)
            w_head_nxt = 8'd0;
        else if (w_wr_en && (r_wr == w_rd_nxt))
            w_head_nxt = w_code;
        else
            w_head_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'd0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'd0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr] <= w_code;
                r_wr        <= r_wr + 1'b1;
            end
            r_rd        <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_key_valid <= (w_count_nxt != '0);
            r_key_code  <= w_head_nxt;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (i_clr_overflow)
                r_ovf <= 1'b0;
        end
    end

    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;
    assign o_overflow  = r_ovf;

endmodule
